// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Types and helpers shared by the FIFO family (single-clock and async variants).
//   lvl_width  : width of the pointer and level counters for a given address width
//   thresh_ge  : almost-full style compare (level >= threshold)
//   thresh_le  : almost-empty style compare (level <= threshold)
//   fifo_flags_t : bundle of registered status flags driven to the FIFO ports
// -----------------------------------------------------------------------------
package fifo_pkg;

   // Pointers and level carry one extra bit so that 0 and DEPTH are distinct.
   function automatic int lvl_width(input int aw);
      return aw + 32'sd1;
   endfunction

   function automatic logic thresh_ge(input int lvl, input int th);
      return (lvl >= th);
   endfunction

   function automatic logic thresh_le(input int lvl, input int th);
      return (lvl <= th);
   endfunction

   typedef struct packed {
      logic wfull;
      logic rempty;
      logic walmost_full;
      logic ralmost_empty;
      logic overflow;
      logic underflow;
   } fifo_flags_t;

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Simple dual-port storage, DWIDTH x 2**AWIDTH, one write port and one
// registered read port. Contents are not reset; only the read register is.
// Ports:
//   clk, rstn      : clock, asynchronous active-low reset (read register only)
//   we/waddr/wdata : write port, captured on the rising edge
//   re/raddr       : read enable/address; rdata loads mem[raddr] when re=1
//   rdata          : registered read data, holds while re=0
// -----------------------------------------------------------------------------
module fifo_mem #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 3
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              we,
   input  logic [AWIDTH-1:0] waddr,
   input  logic [DWIDTH-1:0] wdata,
   input  logic              re,
   input  logic [AWIDTH-1:0] raddr,
   output logic [DWIDTH-1:0] rdata
);

   localparam int DEPTH = 32'sd1 << AWIDTH;

   logic [DWIDTH-1:0] mem_r [DEPTH];
   logic [DWIDTH-1:0] rdata_r;

   // Write port: storage array, no reset so it maps onto RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Registered read port: holds its value unless a read is requested.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdata_r <= '0;
      end else if (re) begin
         rdata_r <= mem_r[raddr];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/sync_fifo_lvl.sv
// -----------------------------------------------------------------------------
// sync_fifo_lvl
// Single-clock FIFO with level output, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a synchronous clear.
// Optional macro SYNC_FIFO_FWFT_EN selects first-word-fall-through reads:
// the head word is presented on rdata whenever rempty=0 and rden pops it.
// Without the macro, rdata is loaded one cycle after an accepted read.
// Ports:
//   clk, rstn       : clock, asynchronous active-low reset
//   clr             : synchronous clear of contents and error flags
//   wren, wdata     : write request and data
//   rden            : read/pop request
//   rdata           : read data (registered)
//   wfull, rempty   : full / nothing readable
//   walmost_full    : level >= AF_THRESH
//   ralmost_empty   : level <= AE_THRESH
//   level           : entries held, 0..DEPTH
//   overflow        : sticky, write attempted while full
//   underflow       : sticky, read attempted while empty
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module sync_fifo_lvl
   import fifo_pkg::*;
#(
   parameter int DWIDTH    = 32,
   parameter int AWIDTH    = 3,
   parameter int AF_THRESH = (32'sd1 << AWIDTH) - 32'sd2,
   parameter int AE_THRESH = 32'sd2
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         clr,
   input  logic                         wren,
   input  logic [DWIDTH-1:0]            wdata,
   input  logic                         rden,
   output logic [DWIDTH-1:0]            rdata,
   output logic                         wfull,
   output logic                         rempty,
   output logic                         walmost_full,
   output logic                         ralmost_empty,
   output logic [lvl_width(AWIDTH)-1:0] level,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int            LW        = lvl_width(AWIDTH);
   localparam int            DEPTH     = 32'sd1 << AWIDTH;
   localparam logic [LW-1:0] LVL_ONE   = LW'(1);
   localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
   localparam fifo_flags_t   FLAGS_RST = '{
      wfull:         1'b0,
      rempty:        1'b1,
      walmost_full:  thresh_ge(32'sd0, AF_THRESH),
      ralmost_empty: thresh_le(32'sd0, AE_THRESH),
      overflow:      1'b0,
      underflow:     1'b0
   };

   logic [LW-1:0] wptr_r, rptr_r, level_r;
   logic [LW-1:0] wptr_nxt_s, rptr_nxt_s, level_nxt_s;
   fifo_flags_t   flags_r, flags_nxt_s;
   logic          acc_wr_s, acc_rd_s, mem_re_s;
`ifdef SYNC_FIFO_FWFT_EN
   // valid_r marks that the read register holds the head word; level counts
   // it together with the words still in memory (mem_cnt_s).
   logic          valid_r, valid_nxt_s, load_s;
   logic [LW-1:0] mem_cnt_s;
`endif

   // Next-state for pointers, level and flags; clr overrides everything.
   always_comb begin
      acc_wr_s    = wren & ~flags_r.wfull & ~clr;
      acc_rd_s    = rden & ~flags_r.rempty & ~clr;
      wptr_nxt_s  = wptr_r;
      rptr_nxt_s  = rptr_r;
      level_nxt_s = level_r;
      flags_nxt_s = flags_r;
      mem_re_s    = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
      valid_nxt_s = valid_r;
      mem_cnt_s   = wptr_r - rptr_r;
      // Refill the read register when it is empty or being popped, using only
      // words already committed to memory before this edge.
      load_s      = (~valid_r | acc_rd_s) & (mem_cnt_s != '0) & ~clr;
`endif
      if (clr) begin
         wptr_nxt_s  = '0;
         rptr_nxt_s  = '0;
         level_nxt_s = '0;
         flags_nxt_s = FLAGS_RST;
`ifdef SYNC_FIFO_FWFT_EN
         valid_nxt_s = 1'b0;
`endif
      end else begin
         if (acc_wr_s) begin
            wptr_nxt_s = wptr_r + LVL_ONE;
         end else begin
            wptr_nxt_s = wptr_r;
         end
`ifdef SYNC_FIFO_FWFT_EN
         if (load_s) begin
            mem_re_s    = 1'b1;
            rptr_nxt_s  = rptr_r + LVL_ONE;
            valid_nxt_s = 1'b1;
         end else if (acc_rd_s) begin
            valid_nxt_s = 1'b0;
         end else begin
            valid_nxt_s = valid_r;
         end
`else
         if (acc_rd_s) begin
            mem_re_s   = 1'b1;
            rptr_nxt_s = rptr_r + LVL_ONE;
         end else begin
            rptr_nxt_s = rptr_r;
         end
`endif
         case ({acc_wr_s, acc_rd_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
         endcase
         flags_nxt_s.wfull         = (level_nxt_s == LVL_FULL);
         flags_nxt_s.walmost_full  = thresh_ge(int'(level_nxt_s), AF_THRESH);
         flags_nxt_s.ralmost_empty = thresh_le(int'(level_nxt_s), AE_THRESH);
         // A same-cycle read never makes room for a write into a full FIFO,
         // and a same-cycle write never satisfies a read from an empty one.
         flags_nxt_s.overflow      = flags_r.overflow  | (wren & flags_r.wfull);
         flags_nxt_s.underflow     = flags_r.underflow | (rden & flags_r.rempty);
`ifdef SYNC_FIFO_FWFT_EN
         flags_nxt_s.rempty        = ~valid_nxt_s;
`else
         flags_nxt_s.rempty        = (level_nxt_s == '0);
`endif
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         level_r <= '0;
         flags_r <= FLAGS_RST;
`ifdef SYNC_FIFO_FWFT_EN
         valid_r <= 1'b0;
`endif
      end else begin
         wptr_r  <= wptr_nxt_s;
         rptr_r  <= rptr_nxt_s;
         level_r <= level_nxt_s;
         flags_r <= flags_nxt_s;
`ifdef SYNC_FIFO_FWFT_EN
         valid_r <= valid_nxt_s;
`endif
      end
   end

   fifo_mem #(
      .DWIDTH (DWIDTH),
      .AWIDTH (AWIDTH)
   ) u_mem (
      .clk   (clk),
      .rstn  (rstn),
      .we    (acc_wr_s),
      .waddr (wptr_r[AWIDTH-1:0]),
      .wdata (wdata),
      .re    (mem_re_s),
      .raddr (rptr_r[AWIDTH-1:0]),
      .rdata (rdata)
   );

   assign level         = level_r;
   assign wfull         = flags_r.wfull;
   assign rempty        = flags_r.rempty;
   assign walmost_full  = flags_r.walmost_full;
   assign ralmost_empty = flags_r.ralmost_empty;
   assign overflow      = flags_r.overflow;
   assign underflow     = flags_r.underflow;

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_lvl
// Self-checking bench for sync_fifo_lvl (DEPTH 8, AF 6, AE 2). Works in both
// read modes; define SYNC_FIFO_FWFT_EN for the FWFT build.
// Reference model: a queue of (data, write-edge) entries. In FWFT mode the
// head is visible once the edge after its write has passed.
// -----------------------------------------------------------------------------
module tb_sync_fifo_lvl;

   localparam int DW    = 32;
   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 2;
`ifdef SYNC_FIFO_FWFT_EN
   localparam bit FWFT = 1'b1;
`else
   localparam bit FWFT = 1'b0;
`endif

   logic          clk   = 1'b0;
   logic          rstn  = 1'b0;
   logic          clr   = 1'b0;
   logic          wren  = 1'b0;
   logic          rden  = 1'b0;
   logic [DW-1:0] wdata = '0;
   logic [DW-1:0] rdata;
   logic          wfull, rempty, walmost_full, ralmost_empty, overflow, underflow;
   logic [AW:0]   level;

   typedef struct {
      logic [DW-1:0] d;
      int            we;
   } ent_t;

   ent_t          q[$];
   int            edge_cnt  = 0;
   logic [DW-1:0] exp_rdata = '0;
   bit            m_ovf     = 1'b0;
   bit            m_unf     = 1'b0;
   int            n_checks  = 0;
   int            n_pass    = 0;

   sync_fifo_lvl #(
      .DWIDTH(DW), .AWIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE)
   ) dut (
      .clk(clk), .rstn(rstn), .clr(clr), .wren(wren), .wdata(wdata), .rden(rden),
      .rdata(rdata), .wfull(wfull), .rempty(rempty), .walmost_full(walmost_full),
      .ralmost_empty(ralmost_empty), .level(level), .overflow(overflow),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   // Is there a readable head word after the most recent edge?
   function automatic bit m_vis();
      if (q.size() == 0) return 1'b0;
      if (!FWFT) return 1'b1;
      return (q[0].we < edge_cnt);
   endfunction

   // One clock cycle of stimulus plus the matching reference-model update.
   task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
      bit   m_empty;
      bit   m_full;
      ent_t e;
      m_empty = !m_vis();
      m_full  = (q.size() == DEPTH);
      wren = w; wdata = d; rden = r; clr = c;
      @(posedge clk);
      edge_cnt++;
      if (c) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         if (w && m_full) m_ovf = 1'b1;
         if (r && m_empty) m_unf = 1'b1;
         if (r && !m_empty) begin
            e = q.pop_front();
            if (!FWFT) exp_rdata = e.d;
         end
         if (w && !m_full) q.push_back('{d, edge_cnt});
      end
      if (FWFT && m_vis()) exp_rdata = q[0].d;
      #1;
      wren = 1'b0; rden = 1'b0; clr = 1'b0;
   endtask

   task automatic apply_reset();
      #2 rstn = 1'b0;
      q.delete();
      exp_rdata = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      repeat (2) @(posedge clk);
      #2 rstn = 1'b1;
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      n_checks++; if (rempty !== 1'b1) $display("FAIL reset_rempty: got %0b want 1", rempty); else n_pass++;
      n_checks++; if (ralmost_empty !== 1'b1) $display("FAIL reset_rae: got %0b want 1", ralmost_empty); else n_pass++;
      n_checks++; if (wfull !== 1'b0) $display("FAIL reset_wfull: got %0b want 0", wfull); else n_pass++;
      n_checks++; if (walmost_full !== 1'b0) $display("FAIL reset_waf: got %0b want 0", walmost_full); else n_pass++;
      n_checks++; if (level !== 4'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
      n_checks++; if (rdata !== 32'd0) $display("FAIL reset_rdata: got %0h want 0", rdata); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %0b want 0", overflow); else n_pass++;
      n_checks++; if (underflow !== 1'b0) $display("FAIL reset_unf: got %0b want 0", underflow); else n_pass++;
   endtask

   task automatic test_fill_drain();
      logic [DW-1:0] want;
      step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 1; i <= DEPTH; i++) begin
         step(1'b1, 32'(i), 1'b0, 1'b0);
         n_checks++; if (level !== 4'(i)) $display("FAIL fill_level[%0d]: got %0d want %0d", i, level, i); else n_pass++;
         n_checks++; if (walmost_full !== 1'(i >= AF)) $display("FAIL fill_waf[%0d]: got %0b want %0b", i, walmost_full, i >= AF); else n_pass++;
         n_checks++; if (wfull !== 1'(i == DEPTH)) $display("FAIL fill_wfull[%0d]: got %0b want %0b", i, wfull, i == DEPTH); else n_pass++;
         n_checks++; if (ralmost_empty !== 1'(i <= AE)) $display("FAIL fill_rae[%0d]: got %0b want %0b", i, ralmost_empty, i <= AE); else n_pass++;
      end
      for (int i = 1; i <= DEPTH; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         want = 32'(i);
         n_checks++; if (rdata !== want) $display("FAIL drain_head[%0d]: got %0h want %0h", i, rdata, want); else n_pass++;
         step(1'b0, '0, 1'b1, 1'b0);
`else
         step(1'b0, '0, 1'b1, 1'b0);
         want = 32'(i);
         n_checks++; if (rdata !== want) $display("FAIL drain_data[%0d]: got %0h want %0h", i, rdata, want); else n_pass++;
`endif
      end
      n_checks++; if (rempty !== 1'b1) $display("FAIL drain_rempty: got %0b want 1", rempty); else n_pass++;
      n_checks++; if (level !== 4'd0) $display("FAIL drain_level: got %0d want 0", level); else n_pass++;
   endtask

   task automatic test_overflow_clr();
      logic [DW-1:0] want;
      step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 1; i <= DEPTH; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
      step(1'b1, 32'd9, 1'b0, 1'b0);
      n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %0b want 1", overflow); else n_pass++;
      n_checks++; if (level !== 4'd8) $display("FAIL ovf_level: got %0d want 8", level); else n_pass++;
      for (int i = 1; i <= DEPTH; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         want = 32'(i);
         n_checks++; if (rdata !== want) $display("FAIL ovf_head[%0d]: got %0h want %0h", i, rdata, want); else n_pass++;
         step(1'b0, '0, 1'b1, 1'b0);
`else
         step(1'b0, '0, 1'b1, 1'b0);
         want = 32'(i);
         n_checks++; if (rdata !== want) $display("FAIL ovf_data[%0d]: got %0h want %0h", i, rdata, want); else n_pass++;
`endif
      end
      n_checks++; if (rempty !== 1'b1) $display("FAIL ovf_no_ninth: rempty got %0b want 1", rempty); else n_pass++;
      n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %0b want 1", overflow); else n_pass++;
      step(1'b0, '0, 1'b0, 1'b1);
      n_checks++; if (level !== 4'd0) $display("FAIL clr_level: got %0d want 0", level); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL clr_ovf: got %0b want 0", overflow); else n_pass++;
      n_checks++; if (rempty !== 1'b1) $display("FAIL clr_rempty: got %0b want 1", rempty); else n_pass++;
   endtask

   task automatic test_underflow();
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b1, 32'h55, 1'b1, 1'b0);
      n_checks++; if (underflow !== 1'b1) $display("FAIL unf_flag: got %0b want 1", underflow); else n_pass++;
      n_checks++; if (level !== 4'd1) $display("FAIL unf_level: got %0d want 1", level); else n_pass++;
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (rdata !== 32'h55) $display("FAIL unf_data: got %0h want 55", rdata); else n_pass++;
      n_checks++; if (level !== 4'd0) $display("FAIL unf_level_after: got %0d want 0", level); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] prev;
      step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 32'(100 + i), 1'b0, 1'b0);
      prev = rdata;
      for (int k = 0; k < 20; k++) begin
         step(1'b1, 32'(104 + k), 1'b1, 1'b0);
         n_checks++; if (level !== 4'd4) $display("FAIL b2b_level[%0d]: got %0d want 4", k, level); else n_pass++;
         n_checks++; if (rdata !== exp_rdata) $display("FAIL b2b_data[%0d]: got %0h want %0h", k, rdata, exp_rdata); else n_pass++;
         if (k > 0) begin
            n_checks++; if (rdata !== prev + 32'd1) $display("FAIL b2b_contig[%0d]: got %0h want %0h", k, rdata, prev + 32'd1); else n_pass++;
         end
         prev = rdata;
      end
   endtask

   task automatic test_random();
      bit w, r, c;
      for (int k = 0; k < 400; k++) begin
         // Alternate fill-biased and drain-biased phases to reach both ends.
         if ((k / 40) % 2 == 0) begin
            w = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) == 0);
         end else begin
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) != 0);
         end
         c = ($urandom_range(0, 79) == 0);
         step(w, $urandom, r, c);
         n_checks++; if (level !== 4'(q.size())) $display("FAIL rnd_level[%0d]: got %0d want %0d", k, level, q.size()); else n_pass++;
         n_checks++; if (wfull !== 1'(q.size() == DEPTH)) $display("FAIL rnd_wfull[%0d]: got %0b", k, wfull); else n_pass++;
         n_checks++; if (rempty !== !m_vis()) $display("FAIL rnd_rempty[%0d]: got %0b want %0b", k, rempty, !m_vis()); else n_pass++;
         n_checks++; if (walmost_full !== 1'(q.size() >= AF)) $display("FAIL rnd_waf[%0d]: got %0b", k, walmost_full); else n_pass++;
         n_checks++; if (ralmost_empty !== 1'(q.size() <= AE)) $display("FAIL rnd_rae[%0d]: got %0b", k, ralmost_empty); else n_pass++;
         n_checks++; if (overflow !== m_ovf) $display("FAIL rnd_ovf[%0d]: got %0b want %0b", k, overflow, m_ovf); else n_pass++;
         n_checks++; if (underflow !== m_unf) $display("FAIL rnd_unf[%0d]: got %0b want %0b", k, underflow, m_unf); else n_pass++;
         n_checks++; if (rdata !== exp_rdata) $display("FAIL rnd_rdata[%0d]: got %0h want %0h", k, rdata, exp_rdata); else n_pass++;
      end
   endtask

   task automatic test_prefetch_and_reset();
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b1, 32'hA, 1'b0, 1'b0);
      n_checks++; if (level !== 4'd1) $display("FAIL pf_level: got %0d want 1", level); else n_pass++;
`ifdef SYNC_FIFO_FWFT_EN
      n_checks++; if (rempty !== 1'b1) $display("FAIL pf_rempty_n: got %0b want 1", rempty); else n_pass++;
      step(1'b0, '0, 1'b0, 1'b0);
      n_checks++; if (rempty !== 1'b0) $display("FAIL pf_rempty_n1: got %0b want 0", rempty); else n_pass++;
      n_checks++; if (rdata !== 32'hA) $display("FAIL pf_rdata: got %0h want a", rdata); else n_pass++;
`else
      n_checks++; if (rempty !== 1'b0) $display("FAIL std_rempty_n: got %0b want 0", rempty); else n_pass++;
      step(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (rdata !== 32'hA) $display("FAIL std_rdata: got %0h want a", rdata); else n_pass++;
`endif
      for (int i = 0; i < 3; i++) step(1'b1, 32'(200 + i), 1'b1, 1'b0);
      apply_reset();
      n_checks++; if (level !== 4'd0) $display("FAIL mrst_level: got %0d want 0", level); else n_pass++;
      n_checks++; if (rempty !== 1'b1) $display("FAIL mrst_rempty: got %0b want 1", rempty); else n_pass++;
      n_checks++; if (rdata !== 32'd0) $display("FAIL mrst_rdata: got %0h want 0", rdata); else n_pass++;
      n_checks++; if (ralmost_empty !== 1'b1) $display("FAIL mrst_rae: got %0b want 1", ralmost_empty); else n_pass++;
      n_checks++; if (wfull !== 1'b0) $display("FAIL mrst_wfull: got %0b want 0", wfull); else n_pass++;
      n_checks++; if (underflow !== 1'b0) $display("FAIL mrst_unf: got %0b want 0", underflow); else n_pass++;
      #3 rstn = 1'b1;
      step(1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow_clr();
      test_underflow();
      test_back_to_back();
      test_random();
      test_prefetch_and_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
